debug_mem_responder: RTL and testbench
======================================

DEBUG_MEM_RESPONDER -- requirements
Module: debug_mem_responder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: max cycles spent in REQ+WAIT before abort.
REQ-002 Parameter ERR_WORD, default 32'hDEAD_BEEF: value returned on dbg_load when a transaction times out.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  accept new debug requests only when high (CPU halted).
REQ-006 dbg_addr  in  32  byte address; bits [1:0] forced to 0 internally.
REQ-007 dbg_read  in  1  read request, sampled in IDLE.
REQ-008 dbg_write  in  4  byte-lane write strobes; nonzero = write request.
REQ-009 dbg_store  in  32  write data.
REQ-010 dbg_done  in  1  initiator acknowledge of response.
REQ-011 dbg_ready  out  1  response valid.
REQ-012 dbg_load  out  32  read data / response word.
REQ-013 dbg_error  out  1  last transaction timed out.
REQ-014 mem_req  out  1  downstream request.
REQ-015 mem_we  out  1  downstream write enable.
REQ-016 mem_addr  out  32  downstream word-aligned address.
REQ-017 mem_wstrb  out  4  downstream byte strobes.
REQ-018 mem_wdata  out  32  downstream write data.
REQ-019 mem_gnt  in  1  downstream accepts request this cycle.
REQ-020 mem_rvalid  in  1  downstream read data valid; never in the same cycle as its mem_gnt.
REQ-021 mem_rdata  in  32  downstream read data.

Function
REQ-022 The block SHALL use FSM states IDLE, REQ, WAIT, RESP.
REQ-023 IDLE: if enable && (dbg_read || dbg_write!=0), latch {dbg_addr & ~3, dbg_store, dbg_write, is_read}, clear dbg_error, clear timeout counter, and go to REQ.
REQ-024 dbg_read and nonzero dbg_write in the same cycle SHALL be treated as a read; the write is dropped.
REQ-025 REQ: mem_req=1 with mem_we/mem_addr/mem_wstrb/mem_wdata held stable from latched values until mem_gnt; mem_we=!is_read; mem_wstrb=0 for reads.
REQ-026 REQ with mem_gnt: write -> RESP with dbg_load=0; read -> WAIT; mem_req deasserts the following cycle.
REQ-027 WAIT: mem_req=0; on mem_rvalid capture mem_rdata into dbg_load and go to RESP; mem_rvalid SHALL be ignored in every other state.
REQ-028 RESP: dbg_ready=1 and dbg_load stable; on dbg_done go to IDLE; dbg_ready=0 the cycle after dbg_done is sampled.
REQ-029 Latency: request sampled at edge T; mem_req high in cycle T+1; mem_gnt in T+1; mem_rvalid in T+2; dbg_ready high in T+3. Write with gnt in T+1: dbg_ready high in T+2.
REQ-030 Timeout counter SHALL be 10 bits minimum ($clog2(TIMEOUT_CYCLES+1)), increment each cycle in REQ or WAIT, saturate, and never wrap.
REQ-031 When the counter reaches TIMEOUT_CYCLES: mem_req=0 next cycle, dbg_load=ERR_WORD, dbg_error=1, go to RESP; gnt or rvalid arriving in that same cycle SHALL be ignored.
REQ-032 dbg_error SHALL be sticky until the next accepted request.
REQ-033 dbg_read/dbg_write outside IDLE SHALL be ignored, not queued; dbg_done outside RESP SHALL be ignored.
REQ-034 enable falling mid-transaction SHALL NOT abort it; the transaction completes normally.
REQ-035 dbg_load SHALL hold its last value between transactions.

Reset
REQ-036 On rst: state=IDLE; dbg_ready=0, dbg_load=0, dbg_error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0; counter=0.
REQ-037 rst asserted in any state SHALL abandon the transaction at the next edge with no further mem_req; the late downstream mem_rvalid SHALL be ignored.

Verification
REQ-038 Read: addr=0x0000_0013, read pulse, gnt same cycle as req, rvalid+rdata=0x1234_5678 next cycle -> mem_addr=0x10, mem_we=0, dbg_ready at T+3, dbg_load=0x1234_5678; after done, dbg_ready=0 next cycle.
REQ-039 Write: addr=0x40, dbg_write=4'b0011, store=0xA5A5_A5A5, gnt delayed 3 cycles -> mem_req held 4 cycles with stable fields, mem_wstrb=0011, dbg_ready with dbg_load=0.
REQ-040 Timeout: read, gnt never asserted, TIMEOUT_CYCLES=8 -> mem_req drops after 8 cycles, dbg_load=0xDEAD_BEEF, dbg_error=1; the next good read clears dbg_error.
REQ-041 Collisions: read and write=4'hF together -> single read, mem_we=0; second read pulse while in WAIT -> ignored; done before ready -> ignored.
REQ-042 rst asserted in WAIT, then rvalid arrives -> outputs at reset values, dbg_ready stays 0; enable=0 with read pulse -> no mem_req.

Source files
------------

// File: rtl/debug_mem_responder.sv
// Debug-port to memory bridge, one transaction in flight; read answers at T+3, write at T+2 with no grant stall.
// Backpressure: mem_req holds until mem_gnt, and the response holds until dbg_done; a stuck downstream is aborted after TIMEOUT_CYCLES.
module debug_mem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERR_WORD       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] dbg_addr,
  input  logic        dbg_read,
  input  logic [3:0]  dbg_write,
  input  logic [31:0] dbg_store,
  input  logic        dbg_done,
  output logic        dbg_ready,
  output logic [31:0] dbg_load,
  output logic        dbg_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 10) ? CNT_RAW : 10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              timeout;
  logic [31:0]       load_q, load_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;

  // Saturating count of cycles spent in REQ+WAIT; abort on the cycle it reaches the limit.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = (state_q == REQ || state_q == WAIT) && (cnt_inc == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (enable && (dbg_read || (dbg_write != 4'h0))) begin
          // A simultaneous read wins; the write strobes are discarded.
          we_d    = !dbg_read;
          addr_d  = {dbg_addr[31:2], 2'b00};
          wstrb_d = dbg_read ? 4'h0 : dbg_write;
          wdata_d = dbg_store;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          load_d  = ERR_WORD;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mem_gnt) begin
          if (we_q) begin
            load_d  = 32'h0;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          load_d  = ERR_WORD;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mem_rvalid) begin
          load_d  = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (dbg_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 32'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign dbg_ready = (state_q == RESP);
  assign dbg_load  = load_q;
  assign dbg_error = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_debug_mem_responder.sv
// Randomized transaction bench for debug_mem_responder with a per-cycle expectation model.
module tb_debug_mem_responder;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] dbg_addr;
  logic        dbg_read;
  logic [3:0]  dbg_write;
  logic [31:0] dbg_store;
  logic        dbg_done;
  logic        dbg_ready;
  logic [31:0] dbg_load;
  logic        dbg_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  debug_mem_responder #(.TIMEOUT_CYCLES(TO), .ERR_WORD(ERR)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .dbg_addr(dbg_addr), .dbg_read(dbg_read), .dbg_write(dbg_write),
    .dbg_store(dbg_store), .dbg_done(dbg_done), .dbg_ready(dbg_ready),
    .dbg_load(dbg_load), .dbg_error(dbg_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Expected outputs for the current cycle; the model holds the last response.
  bit          chk_en = 1'b0;
  bit          exp_fields = 1'b1;
  logic        exp_req = 1'b0, exp_ready = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_load = 32'h0, exp_addr = 32'h0, exp_wdata = 32'h0;
  logic [3:0]  exp_wstrb = 4'h0;
  logic [31:0] m_load = 32'h0;
  logic        m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    else passed++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
      chk("dbg_ready", {31'h0, dbg_ready}, {31'h0, exp_ready});
      chk("dbg_load", dbg_load, exp_load);
      chk("dbg_error", {31'h0, dbg_error}, {31'h0, exp_err});
      if (exp_req || exp_fields) begin
        chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, exp_wstrb});
        if (exp_we || exp_fields) chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic rq, input logic rdy, input logic [31:0] ld, input logic er);
    exp_req = rq; exp_ready = rdy; exp_load = ld; exp_err = er;
  endtask

  task automatic quiet();
    enable = 1'b0; dbg_read = 1'b0; dbg_write = 4'h0; dbg_done = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // One debug transaction: grant after gd idle REQ cycles, rvalid in WAIT cycle rdly,
  // done after dd RESP cycles. Starts and ends in an IDLE cycle.
  task automatic txn(input bit rd, input logic [3:0] wr, input logic [31:0] addr,
                     input logic [31:0] store, input int gd, input int rdly,
                     input logic [31:0] rdata, input int dd,
                     output int lat, output int reqc, output logic [31:0] s_addr,
                     output logic [3:0] s_wstrb, output logic s_we);
    int spent, wcnt;
    bit granted, fin;
    enable = 1'b1; dbg_read = rd; dbg_write = wr; dbg_addr = addr; dbg_store = store;
    dbg_done = 1'($urandom); mem_gnt = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    exp_we = !rd; exp_addr = {addr[31:2], 2'b00}; exp_wstrb = rd ? 4'h0 : wr; exp_wdata = store;
    step();
    spent = 0; wcnt = 0; granted = 0; fin = 0; reqc = 0;
    s_addr = mem_addr; s_wstrb = mem_wstrb; s_we = mem_we;
    while (!fin) begin
      spent++;
      if (mem_req) reqc++;
      set_exp(!granted, 1'b0, m_load, 1'b0);
      enable = 1'($urandom); dbg_read = 1'($urandom); dbg_write = 4'($urandom);
      dbg_done = 1'($urandom); dbg_addr = $urandom; dbg_store = $urandom; mem_rdata = $urandom;
      if (!granted) begin
        mem_gnt = (spent == gd + 1);
        mem_rvalid = mem_gnt ? 1'b0 : 1'($urandom);
        if (spent == TO) begin
          m_load = ERR; m_err = 1'b1; fin = 1;
        end else if (mem_gnt) begin
          if (rd) granted = 1;
          else begin m_load = 32'h0; m_err = 1'b0; fin = 1; end
        end
      end else begin
        wcnt++;
        mem_rvalid = (wcnt == rdly);
        mem_gnt = mem_rvalid ? 1'b0 : 1'($urandom);
        if (mem_rvalid) mem_rdata = rdata;
        if (spent == TO) begin
          m_load = ERR; m_err = 1'b1; fin = 1;
        end else if (mem_rvalid) begin
          m_load = rdata; m_err = 1'b0; fin = 1;
        end
      end
      step();
    end
    lat = spent + 1;
    for (int k = 0; k <= dd; k++) begin
      set_exp(1'b0, 1'b1, m_load, m_err);
      dbg_done = (k == dd); enable = 1'($urandom); dbg_read = 1'($urandom);
      dbg_write = 4'($urandom); mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom);
      mem_rdata = $urandom;
      step();
    end
    set_exp(1'b0, 1'b0, m_load, m_err);
    quiet();
  endtask

  task automatic idle_noaccept();
    enable = 1'b0; dbg_read = 1'b1; dbg_write = 4'($urandom);
    step();
    quiet();
  endtask

  int          lat, reqc;
  logic [31:0] s_addr;
  logic [3:0]  s_wstrb;
  logic        s_we;

  initial begin
    rst = 1'b1; quiet(); dbg_addr = 32'h0; dbg_store = 32'h0; mem_rdata = 32'h0;
    repeat (2) step();
    chk_en = 1'b1;
    rst = 1'b0;
    step();
    exp_fields = 1'b0;

    // Read: unaligned address, immediate grant, data next cycle.
    txn(1'b1, 4'h0, 32'h0000_0013, 32'h0, 0, 1, 32'h1234_5678, 0, lat, reqc, s_addr, s_wstrb, s_we);
    chk("rd_latency", lat, 3);
    chk("rd_addr", s_addr, 32'h10);
    chk("rd_we", {31'h0, s_we}, 32'h0);
    chk("rd_load", dbg_load, 32'h1234_5678);
    chk("rd_ready_after_done", {31'h0, dbg_ready}, 32'h0);

    // Write: grant delayed three cycles.
    txn(1'b0, 4'b0011, 32'h40, 32'hA5A5_A5A5, 3, 1, 32'h0, 1, lat, reqc, s_addr, s_wstrb, s_we);
    chk("wr_req_cycles", reqc, 4);
    chk("wr_wstrb", {28'h0, s_wstrb}, 32'h3);
    chk("wr_load", dbg_load, 32'h0);

    txn(1'b0, 4'hF, 32'h44, 32'h0BAD_F00D, 0, 1, 32'h0, 0, lat, reqc, s_addr, s_wstrb, s_we);
    chk("wr_latency", lat, 2);

    // Timeout: grant never comes.
    txn(1'b1, 4'h0, 32'h80, 32'h0, 50, 1, 32'h0, 2, lat, reqc, s_addr, s_wstrb, s_we);
    chk("to_req_cycles", reqc, 8);
    chk("to_load", dbg_load, 32'hDEAD_BEEF);
    chk("to_error", {31'h0, dbg_error}, 32'h1);

    txn(1'b1, 4'h0, 32'h84, 32'h0, 1, 2, 32'hCAFE_0001, 0, lat, reqc, s_addr, s_wstrb, s_we);
    chk("err_cleared", {31'h0, dbg_error}, 32'h0);
    chk("good_load", dbg_load, 32'hCAFE_0001);

    // Read and full write together: a single read.
    txn(1'b1, 4'hF, 32'h88, 32'hFFFF_FFFF, 0, 1, 32'h7777_0000, 0, lat, reqc, s_addr, s_wstrb, s_we);
    chk("coll_we", {31'h0, s_we}, 32'h0);
    chk("coll_wstrb", {28'h0, s_wstrb}, 32'h0);

    // Grant exactly on the timeout cycle, and a timeout while waiting for data.
    txn(1'b1, 4'h0, 32'h90, 32'h0, 7, 1, 32'h1111_1111, 0, lat, reqc, s_addr, s_wstrb, s_we);
    chk("gnt_on_timeout_load", dbg_load, 32'hDEAD_BEEF);
    txn(1'b1, 4'h0, 32'h94, 32'h0, 2, 10, 32'h2222_2222, 0, lat, reqc, s_addr, s_wstrb, s_we);
    chk("wait_timeout_latency", lat, 9);

    // Reset while waiting for read data, then the late rvalid.
    enable = 1'b1; dbg_read = 1'b1; dbg_addr = 32'h104;
    exp_we = 1'b0; exp_addr = 32'h104; exp_wstrb = 4'h0;
    step();
    set_exp(1'b1, 1'b0, m_load, 1'b0);
    dbg_read = 1'b0; mem_gnt = 1'b1;
    step();
    set_exp(1'b0, 1'b0, m_load, 1'b0);
    mem_gnt = 1'b0; rst = 1'b1;
    step();
    m_load = 32'h0; m_err = 1'b0;
    exp_fields = 1'b1; exp_we = 1'b0; exp_addr = 32'h0; exp_wstrb = 4'h0; exp_wdata = 32'h0;
    set_exp(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("rst_ready", {31'h0, dbg_ready}, 32'h0);
    chk("rst_load", dbg_load, 32'h0);
    enable = 1'b0; dbg_read = 1'b1;
    step();
    dbg_read = 1'b0;
    step();
    chk("disabled_no_req", {31'h0, mem_req}, 32'h0);
    exp_fields = 1'b0;

    for (int i = 0; i < 60; i++) begin
      bit          rd;
      logic [3:0]  wr;
      int          gd;
      rd = 1'($urandom);
      wr = 4'($urandom);
      if (!rd && wr == 4'h0) wr = 4'h1;
      gd = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
      txn(rd, wr, $urandom, $urandom, gd, int'($urandom_range(1, 5)), $urandom,
          int'($urandom_range(0, 2)), lat, reqc, s_addr, s_wstrb, s_we);
      if ($urandom_range(0, 2) == 0) idle_noaccept();
    end

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
